fetch_unit: RTL

Instruction fetch stage of the single-issue core. Drives the instruction read port of the unified memory, which has one-cycle synchronous read latency. Tracks the PC and in-flight requests, and buffers returned words in a 2-entry queue. Presents {pc, instruction} to decode over a valid/ready handshake, and accepts redirects from execute.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/fetch_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro used by this slice: FETCH_MISALIGN_EN.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int FETCH_DEPTH = 2;

  // Encoding decode inserts for bubbles (addi x0, x0, 0).
  localparam logic [XLEN-1:0] NOP_INST  = 32'h0000_0013;
  // Clears the byte-offset bits of a PC.
  localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            fault;
  } fetch_entry_t;

  // Byte PC to memory word address (zero-extended).
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] pc);
    return {2'b00, pc[XLEN-1:2]};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO holding fetched {pc, inst, fault} entries.
// Flush wins over push/pop. Push into a full FIFO is only accepted
// together with a pop; the parent's credit logic keeps it from overflowing.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [FETCH_DEPTH];
  fetch_entry_t mem_d [FETCH_DEPTH];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok_s, push_ok_s;

  assign pop_ok_s  = pop && (count_q != 2'd0);
  assign push_ok_s = push && ((count_q != 2'd2) || pop_ok_s);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads to a one-cycle-latency memory,
// buffers returned words in a 2-entry FIFO and hands {pc, inst} to decode.
// Optional macro FETCH_MISALIGN_EN: a misaligned redirect produces a single
// fault entry and halts issue until the next redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic [XLEN-1:0] inst_ain,
  input  logic [XLEN-1:0] inst_dout,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic            out_fault
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            epoch_q, epoch_d;
  logic            inflight_epoch_q, inflight_epoch_d;

  logic [1:0]      fifo_count_s;
  fetch_entry_t    head_s;
  fetch_entry_t    push_entry_s;
  logic            push_s, pop_s, issue_s, resp_ok_s;
  logic [2:0]      credit_s;
  logic [XLEN-1:0] redirect_target_s;
  logic            halted_s;
  logic            fault_push_s;

`ifdef FETCH_MISALIGN_EN
  logic halted_q, halted_d;
  logic fault_pend_q, fault_pend_d;
  logic misalign_s;

  assign misalign_s        = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redirect_target_s = redirect_pc;
  assign halted_s          = halted_q;
  assign fault_push_s      = fault_pend_q;

  // A misaligned redirect halts issue and schedules one fault entry.
  always_comb begin
    halted_d     = halted_q;
    fault_pend_d = 1'b0;
    if (redirect_valid) begin
      halted_d     = misalign_s;
      fault_pend_d = misalign_s;
    end else begin
      halted_d     = halted_q;
      fault_pend_d = 1'b0;
    end
  end

  // Halt and pending-fault registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      halted_q     <= 1'b0;
      fault_pend_q <= 1'b0;
    end else begin
      halted_q     <= halted_d;
      fault_pend_q <= fault_pend_d;
    end
  end
`else
  // Byte offset of a redirect target is dropped; faults never occur.
  assign redirect_target_s = redirect_pc & WORD_MASK;
  assign halted_s          = 1'b0;
  assign fault_push_s      = 1'b0;
`endif

  assign out_valid = (fifo_count_s != 2'd0);
  assign pop_s     = out_valid && out_ready;
  // Entries that will occupy the FIFO once the outstanding read lands.
  assign credit_s  = {1'b0, fifo_count_s} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign issue_s   = !redirect_valid && !halted_s && (credit_s < 3'd2);
  assign resp_ok_s = inflight_q && (inflight_epoch_q == epoch_q);
  assign push_s    = resp_ok_s || fault_push_s;
  assign inst_ain  = word_addr(fetch_pc_q);

  // Select what enters the FIFO: a returned word or a fault marker.
  always_comb begin
    push_entry_s = '0;
    if (fault_push_s) begin
      push_entry_s.pc    = fetch_pc_q;
      push_entry_s.inst  = 32'h0000_0000;
      push_entry_s.fault = 1'b1;
    end else begin
      push_entry_s.pc    = inflight_pc_q;
      push_entry_s.inst  = inst_dout;
      push_entry_s.fault = 1'b0;
    end
  end

  // PC, outstanding-request and epoch next-state.
  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    inflight_d       = 1'b0;
    inflight_pc_d    = inflight_pc_q;
    epoch_d          = epoch_q;
    inflight_epoch_d = inflight_epoch_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_target_s;
      epoch_d    = ~epoch_q;
      inflight_d = 1'b0;
    end else if (issue_s) begin
      inflight_d       = 1'b1;
      inflight_pc_d    = fetch_pc_q;
      inflight_epoch_d = epoch_q;
      fetch_pc_d       = fetch_pc_q + 32'd4;
    end else begin
      inflight_d = 1'b0;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q       <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= 32'h0000_0000;
      epoch_q          <= 1'b0;
      inflight_epoch_q <= 1'b0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      epoch_q          <= epoch_d;
      inflight_epoch_q <= inflight_epoch_d;
    end
  end

  fetch_fifo u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push_s),
    .pop        (pop_s),
    .flush      (redirect_valid),
    .push_entry (push_entry_s),
    .head       (head_s),
    .count      (fifo_count_s)
  );

  assign out_pc    = head_s.pc;
  assign out_inst  = head_s.inst;
  // The stored fault bit is only ever set when misaligned faults are enabled.
  assign out_fault = head_s.fault;

endmodule
